// File: rtl/e800_defs.sv
// rtl/e800_defs.sv - shared FSM encodings and sizing helper for the RAM arbiter.
package e800_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick: first set request at or after ptr.
module rr_select
  import e800_defs::*;
#(
  parameter int c_num_req   = 2,
  parameter int c_ptr_width = ptr_width(c_num_req)
) (
  input  logic [c_num_req-1:0]   req_i,
  input  logic [c_ptr_width-1:0] ptr_i,
  output logic [c_ptr_width-1:0] winner_o,
  output logic                   any_o
);

  function automatic logic [c_ptr_width-1:0] rot_idx(input logic [c_ptr_width-1:0] base,
                                                     input int off);
    int s;
    s = int'(base) + off;
    if (s >= c_num_req) s = s - c_num_req;
    return c_ptr_width'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request to ptr is the last one kept.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int i = c_num_req - 1; i >= 0; i--) begin
      if (req_i[rot_idx(ptr_i, i)]) begin
        winner_o = rot_idx(ptr_i, i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter giving each requester one single-port RAM access.
module ram_arbiter
  import e800_defs::*;
#(
  parameter int c_addr_width = 8,
  parameter int c_data_width = 8,
  parameter int c_num_req    = 2
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [c_num_req-1:0]              i_req,
  input  logic [c_num_req-1:0]              i_we,
  input  logic [c_num_req*c_addr_width-1:0] i_addr,
  input  logic [c_num_req*c_data_width-1:0] i_wdata,
  output logic [c_num_req-1:0]              o_ack,
  output logic [c_data_width-1:0]           o_rdata,
  output logic [c_num_req-1:0]              o_grant,
  output logic                              o_busy,
  output logic                              o_ram_enable_in,
  output logic                              o_ram_enable_out,
  output logic [c_addr_width-1:0]           o_ram_address,
  output logic [c_data_width-1:0]           o_ram_data,
  input  logic [c_data_width-1:0]           i_ram_data
);

  localparam int c_ptr_width = ptr_width(c_num_req);

  state_t                   state_q;
  logic [c_ptr_width-1:0]   ptr_q;
  logic [c_ptr_width-1:0]   win_q;
  logic                     we_q;
  logic [c_addr_width-1:0]  addr_q;
  logic [c_data_width-1:0]  wdata_q;
  logic [c_data_width-1:0]  rdata_q;
  logic [c_num_req-1:0]     ack_q;
  logic [c_num_req-1:0]     grant_q;
  logic                     busy_q;

  logic [c_ptr_width-1:0]   sel_winner;
  logic                     sel_any;

  rr_select #(
    .c_num_req  (c_num_req),
    .c_ptr_width(c_ptr_width)
  ) u_rr_select (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .winner_o(sel_winner),
    .any_o   (sel_any)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (sel_any) begin
            win_q   <= sel_winner;
            we_q    <= i_we[sel_winner];
            addr_q  <= i_addr[int'(sel_winner)*c_addr_width +: c_addr_width];
            wdata_q <= i_wdata[int'(sel_winner)*c_data_width +: c_data_width];
            grant_q <= c_num_req'(1) << sel_winner;
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!we_q) rdata_q <= i_ram_data;
          ack_q   <= grant_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == c_ptr_width'(c_num_req - 1)) ? '0 : win_q + c_ptr_width'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write strobe is masked by reset so an interrupted write never lands in the RAM.
  assign o_ram_enable_in  = (state_q == ST_ACCESS) && we_q && !i_reset;
  assign o_ram_enable_out = (state_q == ST_ACCESS) && !we_q;
  assign o_ram_address    = addr_q;
  assign o_ram_data       = wdata_q;
  assign o_ack            = ack_q;
  assign o_grant          = grant_q;
  assign o_busy           = busy_q;
  assign o_rdata          = rdata_q;

endmodule
